// File: rtl/pool_window_feeder_pkg.sv
// Shared constants and FSM encoding for the pooling window feeder.
package pool_feeder_pkg;
   localparam int WIN    = 7;
   localparam int DATA_W = 8;
   localparam int THR_W  = 24;
   localparam int WORD_W = WIN * DATA_W;

   typedef enum logic [2:0] {
      IDLE,
      THR_SET,
      THR_LOAD,
      RUN,
      FLUSH
   } state_t;
endpackage

// File: rtl/pool_window_feeder_if.sv
// Sample stream in, window/threshold/status out, for one channel row.
interface pool_window_feeder_if;
   import pool_feeder_pkg::*;

   logic                     start;
   logic [THR_W-1:0]         thr_in;
   logic                     s_valid;
   logic                     s_ready;
   logic signed [DATA_W-1:0] s_data;
   logic                     s_last;
   logic [WORD_W-1:0]        in_Data;
   logic                     win_valid;
   logic [THR_W-1:0]         threhold;
   logic                     loadthrehold;
   logic                     bin_valid;
   logic                     row_done;

   // feeder side
   modport slave (
      input  start, thr_in, s_valid, s_data, s_last,
      output s_ready, in_Data, win_valid, threhold, loadthrehold, bin_valid, row_done
   );

   // driver / observer side
   modport master (
      output start, thr_in, s_valid, s_data, s_last,
      input  s_ready, in_Data, win_valid, threhold, loadthrehold, bin_valid, row_done
   );
endinterface

// File: rtl/pool_window_feeder_shreg.sv
// 7-deep signed sample shift register; taps[0] newest, taps[WIN-1] oldest.
module sample_window_shreg
   import pool_feeder_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     shift_en,
   input  logic signed [DATA_W-1:0] din,
   output logic [WORD_W-1:0]        word
);
   logic [WIN-1:0][DATA_W-1:0] taps;

   // shift newest sample in at the bottom; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        taps <= '0;
      else if (clr)      taps <= '0;
      else if (shift_en) taps <= {taps[WIN-2:0], din};
   end

   assign word = taps;
endmodule

// File: rtl/pool_window_feeder.sv
// Assembles strided 7-sample windows and threshold load for the compare block.
module pool_window_feeder
   import pool_feeder_pkg::*;
#(
   parameter int STRIDE = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   pool_window_feeder_if.slave  bus
);
   localparam logic [2:0] FILL_MAX  = 3'(WIN);
   localparam logic [2:0] SINCE_MAX = 3'(STRIDE - 1);
   localparam int         STAGES    = 2;

   state_t              state, state_nxt;
   logic [2:0]          fill, since;
   logic [1:0]          flush_cnt;
   logic [WORD_W-1:0]   win_word;
   logic [STAGES:0]     vld_pipe;
   logic                hs, emit, flush_end;

   assign hs        = bus.s_valid && bus.s_ready;
   assign emit      = hs && !bus.start &&
                      ((fill == FILL_MAX - 3'd1) || (fill == FILL_MAX && since == SINCE_MAX));
   assign flush_end = (state == FLUSH) && (flush_cnt == 2'd2);

   assign bus.s_ready   = (state == RUN);
   assign bus.win_valid = vld_pipe[0];
   assign bus.bin_valid = vld_pipe[STAGES];

   sample_window_shreg u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.start),
      .shift_en (hs),
      .din      (bus.s_data),
      .word     (win_word)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: start restarts from any state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = IDLE;
         THR_SET:  state_nxt = THR_LOAD;
         THR_LOAD: state_nxt = RUN;
         RUN:      if (hs && bus.s_last) state_nxt = FLUSH;
         FLUSH:    if (flush_end) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (bus.start) state_nxt = THR_SET;
   end

   // fill / stride / flush counters; bubbles leave them untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill      <= '0;
         since     <= '0;
         flush_cnt <= '0;
      end else if (bus.start) begin
         fill      <= '0;
         since     <= '0;
         flush_cnt <= '0;
      end else begin
         if (hs) begin
            if (fill != FILL_MAX) fill <= fill + 3'd1;
            // since only runs once the window is full; first window leaves it at 0
            if (fill == FILL_MAX) since <= (since == SINCE_MAX) ? 3'd0 : since + 3'd1;
            else                  since <= 3'd0;
         end
         flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      end
   end

   // registered outputs; bin_valid delay line is not cleared by start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.threhold     <= '0;
         bus.loadthrehold <= 1'b0;
         bus.in_Data      <= '0;
         bus.row_done     <= 1'b0;
         vld_pipe         <= '0;
      end else begin
         if (bus.start) bus.threhold <= bus.thr_in;
         // gated by start so threhold is always settled a cycle ahead of the strobe
         bus.loadthrehold <= (state == THR_SET) && !bus.start;
         if (emit) bus.in_Data <= {win_word[WORD_W-DATA_W-1:0], bus.s_data};
         bus.row_done     <= flush_end && !bus.start;
         vld_pipe         <= {vld_pipe[STAGES-1:0], emit};
      end
   end
endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder (STRIDE = 2).
module tb_pool_window_feeder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   pool_window_feeder_if bus ();

   pool_window_feeder #(.STRIDE(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;

   logic [55:0] wins[$];
   int          wv_cyc[$];
   int          bv_cyc[$];
   int          rd_cyc[$];
   int          lt_cyc[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // advance one clock and log every output pulse seen in the new cycle
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.win_valid) begin
         wins.push_back(bus.in_Data);
         wv_cyc.push_back(cyc);
      end
      if (bus.bin_valid)    bv_cyc.push_back(cyc);
      if (bus.row_done)     rd_cyc.push_back(cyc);
      if (bus.loadthrehold) lt_cyc.push_back(cyc);
   endtask

   task automatic clr_q();
      wins.delete(); wv_cyc.delete(); bv_cyc.delete(); rd_cyc.delete(); lt_cyc.delete();
   endtask

   task automatic do_start(input logic [23:0] thr);
      bus.start  = 1'b1;
      bus.thr_in = thr;
      step();
      bus.start  = 1'b0;
   endtask

   // present one sample until accepted; c returns the handshake cycle
   task automatic send(input logic [7:0] d, input logic last, output int c);
      int guard = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = last;
      while (!bus.s_ready && guard < 20) begin
         step();
         guard++;
      end
      check("send_ready", 64'(bus.s_ready), 64'd1);
      c = cyc;
      step();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   function automatic logic [55:0] win_at(input int i);
      return (i < wins.size()) ? wins[i] : 56'hx;
   endfunction

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      int c, t;
      bus.start = 0; bus.thr_in = '0; bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0;

      // reset state
      repeat (3) step();
      check("rst_thr",    64'(bus.threhold), 64'd0);
      check("rst_load",   64'(bus.loadthrehold), 64'd0);
      check("rst_ready",  64'(bus.s_ready), 64'd0);
      check("rst_data",   64'(bus.in_Data), 64'd0);
      check("rst_wv",     64'(bus.win_valid), 64'd0);
      check("rst_bv",     64'(bus.bin_valid), 64'd0);
      check("rst_rd",     64'(bus.row_done), 64'd0);
      rst_n = 1'b1;
      step();

      // threshold load timing
      clr_q();
      t = cyc;
      do_start(24'h8A305F);
      check("thr_t1",      64'(bus.threhold), 64'h8A305F);
      check("load_t1",     64'(bus.loadthrehold), 64'd0);
      check("ready_t1",    64'(bus.s_ready), 64'd0);
      step();
      check("load_t2",     64'(bus.loadthrehold), 64'd1);
      check("ready_t2",    64'(bus.s_ready), 64'd0);
      check("load_cyc",    64'(qat(lt_cyc, 0)), 64'(t + 2));
      step();
      check("ready_t3",    64'(bus.s_ready), 64'd1);
      check("load_t3",     64'(bus.loadthrehold), 64'd0);

      // single window 1..7
      for (int i = 1; i <= 7; i++) send(8'(i), (i == 7), c);
      repeat (6) step();
      check("sw_count",    64'(wins.size()), 64'd1);
      check("sw_data",     64'(win_at(0)), 64'h01020304050607);
      check("sw_wv_cyc",   64'(qat(wv_cyc, 0)), 64'(c + 1));
      check("sw_bv_cnt",   64'(bv_cyc.size()), 64'd1);
      check("sw_bv_cyc",   64'(qat(bv_cyc, 0)), 64'(c + 3));
      check("sw_rd_cyc",   64'(qat(rd_cyc, 0)), 64'(c + 4));
      check("sw_hold",     64'(bus.in_Data), 64'h01020304050607);
      check("sw_idle_rdy", 64'(bus.s_ready), 64'd0);

      // stride 2 over -5..5
      clr_q();
      do_start(24'h000100);
      for (int i = -5; i <= 5; i++) send(8'(i), (i == 5), c);
      repeat (6) step();
      check("st_count",    64'(wins.size()), 64'd3);
      check("st_w0",       64'(win_at(0)), 64'hFBFCFDFEFF0001);
      check("st_w1",       64'(win_at(1)), 64'hFDFEFF00010203);
      check("st_w2",       64'(win_at(2)), 64'hFF000102030405);
      check("st_gap",      64'(qat(wv_cyc, 1) - qat(wv_cyc, 0)), 64'd2);
      check("st_w2_cyc",   64'(qat(wv_cyc, 2)), 64'(c + 1));
      check("st_bv_cnt",   64'(bv_cyc.size()), 64'd3);
      check("st_rd_cyc",   64'(qat(rd_cyc, 0)), 64'(c + 4));

      // short row with bubbles
      clr_q();
      do_start(24'h000200);
      for (int i = 1; i <= 5; i++) begin
         repeat ($urandom_range(0, 3)) step();
         send(8'(i), (i == 5), c);
      end
      repeat (6) step();
      check("sh_wins",     64'(wins.size()), 64'd0);
      check("sh_bv",       64'(bv_cyc.size()), 64'd0);
      check("sh_rd_cnt",   64'(rd_cyc.size()), 64'd1);
      check("sh_rd_cyc",   64'(qat(rd_cyc, 0)), 64'(c + 4));

      // restart mid-row
      clr_q();
      do_start(24'h111111);
      for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), 1'b0, c);
      do_start(24'h2468AC);
      check("rs_thr",      64'(bus.threhold), 64'h2468AC);
      check("rs_ready",    64'(bus.s_ready), 64'd0);
      step();
      check("rs_load",     64'(bus.loadthrehold), 64'd1);
      for (int i = 1; i <= 7; i++) send(8'(8'h20 + i), (i == 7), c);
      repeat (6) step();
      check("rs_lt_cnt",   64'(lt_cyc.size()), 64'd2);
      check("rs_count",    64'(wins.size()), 64'd1);
      check("rs_data",     64'(win_at(0)), 64'h21222324252627);
      check("rs_rd_cnt",   64'(rd_cyc.size()), 64'd1);

      // reset with fill = 6
      clr_q();
      do_start(24'h0F0F0F);
      for (int i = 1; i <= 6; i++) send(8'(8'h30 + i), 1'b0, c);
      #2 rst_n = 1'b0;
      #1;
      check("mr_thr",      64'(bus.threhold), 64'd0);
      check("mr_data",     64'(bus.in_Data), 64'd0);
      check("mr_ready",    64'(bus.s_ready), 64'd0);
      check("mr_load",     64'(bus.loadthrehold), 64'd0);
      check("mr_wv",       64'(bus.win_valid), 64'd0);
      check("mr_bv",       64'(bus.bin_valid), 64'd0);
      check("mr_rd",       64'(bus.row_done), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      clr_q();
      do_start(24'h00ABCD);
      for (int i = 1; i <= 7; i++) send(8'(8'h40 + i), (i == 7), c);
      repeat (6) step();
      check("pr_thr",      64'(bus.threhold), 64'h00ABCD);
      check("pr_lt_cnt",   64'(lt_cyc.size()), 64'd1);
      check("pr_count",    64'(wins.size()), 64'd1);
      check("pr_data",     64'(win_at(0)), 64'h41424344454647);
      check("pr_rd_cyc",   64'(qat(rd_cyc, 0)), 64'(c + 4));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pool_window_feeder.md
# pool_window_feeder

Upstream stage of the 7-input max/threshold compare block. It accepts a per-channel stream of signed 8-bit activations and assembles sliding 7-sample windows at a programmable stride. Each window is presented as a 56-bit word. It also delivers the channel's 24-bit threshold word with a clean load strobe, and flags when the compare block's binary output is valid. One instance serves one channel row at a time.

## Interface
- STRIDE, 2, window advance in accepted samples; legal range 1..7.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a new channel row. Honoured in any state.
- thr_in  in  24  threshold word for the row; sampled on the `start` cycle.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input ready. Handshake occurs when `s_valid && s_ready`.
- s_data  in  8  signed input sample.
- s_last  in  1  marks the last sample of the row; qualified by the handshake.
- in_Data  out  56  window word. Oldest sample is in [55:48], newest in [7:0].
- win_valid  out  1  one-cycle pulse; `in_Data` is a new window this cycle.
- threhold  out  24  registered threshold word; held until the next `start`.
- loadthrehold  out  1  registered one-cycle strobe for the compare block.
- bin_valid  out  1  `win_valid` delayed 2 cycles; marks the cycle in which the compare block's `binary` is valid.
- row_done  out  1  one-cycle pulse; the row is fully processed.

## Operation
- Reset values: all outputs are 0, `in_Data` is 0, the FSM is in IDLE, and all counters are 0.
- States and transitions:
  - IDLE → THR_SET when `start`. `threhold` ← `thr_in`.
  - THR_SET → THR_LOAD. `loadthrehold` = 1 for exactly this state.
  - THR_LOAD → RUN. `s_ready` = 1 only in RUN.
  - RUN → FLUSH on the handshake with `s_last` = 1.
  - FLUSH lasts 3 cycles, then → IDLE with a `row_done` pulse on the IDLE-entry cycle.
- `start` in any non-IDLE state restarts at THR_SET. It clears the window, the fill counter, the stride counter and pending FLUSH timing. Already-issued `bin_valid` pulses in the delay line still complete.
- Window buffer:
  - 7×8-bit shift register. Each handshake shifts the sample in at the newest position.
  - `fill` counts 0..7 and saturates at 7.
- Emission rule:
  - The first window is emitted on the handshake that makes `fill` = 7.
  - After that, a window is emitted every STRIDE handshakes, tracked by a `since` counter 0..STRIDE-1.
- Rows shorter than 7 samples emit no window and still produce FLUSH and `row_done`.
- Tail samples that do not complete a stride are dropped.
- Window count per row of N ≥ 7 samples is floor((N−7)/STRIDE)+1.
- `s_valid` bubbles pause all counters; there are no side effects.
- No backpressure exists from downstream. Windows may be emitted on consecutive cycles when STRIDE = 1.

## Timing
- `start` at cycle t:
  - `threhold` is updated at t+1.
  - `loadthrehold` is high during t+2.
  - `s_ready` rises at t+3.
- `threhold` is stable at least one cycle before and after the `loadthrehold` rising edge. The compare block samples it on that edge.
- A handshake at cycle c that qualifies an emission gives `in_Data` and `win_valid` at c+1 (registered).
- `bin_valid` is at c+3: the compare block registers the max at c+2 and `binary` at c+3.
- Last handshake at cycle c with `s_last`:
  - FLUSH occupies c+1..c+3.
  - `row_done` is at c+4, after the final `bin_valid` at c+3.
- `in_Data` holds its value between emissions.
- `s_ready` is 0 in IDLE, THR_SET, THR_LOAD and FLUSH.

## Structure
- Package `pool_feeder_pkg`:
  - constants WIN = 7, DATA_W = 8, THR_W = 24;
  - FSM state enum {IDLE, THR_SET, THR_LOAD, RUN, FLUSH}.
- Sub-module `sample_window_shreg`:
  - the 7-deep signed 8-bit shift register with synchronous clear;
  - exposes the 56-bit packed word.
- The FSM, counters and the 2-stage `bin_valid` delay live in the top.

## Test plan
- Threshold load: `start` with `thr_in` = 24'h8A3_05F → `threhold` = 24'h8A305F at t+1, `loadthrehold` pulse at t+2, `s_ready` at t+3.
- Single window: STRIDE = 2; samples 1,2,…,7 with `s_last` on 7 → one `win_valid` with `in_Data` = 56'h01020304050607, `bin_valid` 2 cycles later, then `row_done`.
- Stride: STRIDE = 2; 11 samples −5..5 → exactly 3 windows, starting at −5, −3 and −1 (first = 56'hFBFCFDFEFF0001).
- Short row with bubbles: 5 samples with random `s_valid` gaps and `s_last` on the 5th → zero `win_valid`, `row_done` 4 cycles after the last handshake.
- Restart: `start` with new `thr_in` after 4 samples of a row → window cleared; the next row of 7 samples yields a window containing only new samples, and a fresh `loadthrehold` pulse.
- Reset mid-row: deassert `rst_n` in RUN with `fill` = 6 → all outputs 0 immediately; the following row behaves as from power-up.
